// File: rtl/ma_cvxif_offload_queue.sv
// In-order, kill-aware CV-X-IF offload queue between the CVA6 coprocessor interface
// and the matrix accelerator. Committed entries dispatch in program order; responses retire at head.
module ma_cvxif_offload_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_WIDTH = 2,
  parameter logic [6:0]  OPCODE   = 7'b0001011
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [31:0]                issue_instr_i,
  input  logic [XLEN-1:0]            issue_rs1_i,
  input  logic [XLEN-1:0]            issue_rs2_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  output logic                       issue_accept_o,
  output logic                       issue_writeback_o,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       acc_req_valid_o,
  input  logic                       acc_req_ready_i,
  output logic [31:0]                acc_req_instr_o,
  output logic [XLEN-1:0]            acc_req_rs1_o,
  output logic [XLEN-1:0]            acc_req_rs2_o,
  output logic [ID_WIDTH-1:0]        acc_req_id_o,
  input  logic                       acc_rsp_valid_i,
  output logic                       acc_rsp_ready_o,
  input  logic [XLEN-1:0]            acc_rsp_data_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_WIDTH-1:0]        result_id_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {ST_FREE, ST_WAIT, ST_CMT, ST_KILL, ST_ISS} ent_state_e;

  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic [ID_WIDTH-1:0] id;
    logic                we;
  } entry_t;

  ent_state_e    state_q [DEPTH];
  ent_state_e    state_d [DEPTH];
  entry_t        ent_q   [DEPTH];
  entry_t        ent_d   [DEPTH];
  logic [PW-1:0] head_q, head_d, disp_q, disp_d, tail_q, tail_d;

  logic [AW-1:0] head_idx, disp_idx, tail_idx;
  logic          opcode_ok, head_iss, head_we, kill_retire, rsp_hs, req_hs, commit_hit;
  ent_state_e    disp_st, head_st;

  assign head_idx = head_q[AW-1:0];
  assign disp_idx = disp_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];

  // Pointers carry a wrap bit so tail == head only when empty
  assign count_o       = CW'(tail_q - head_q);
  assign issue_ready_o = (count_o != CW'(DEPTH));

  assign opcode_ok         = (issue_instr_i[6:0] == OPCODE);
  assign issue_accept_o    = issue_valid_i & issue_ready_o & opcode_ok;
  assign issue_writeback_o = issue_accept_o & (issue_instr_i[11:7] != 5'd0) & issue_instr_i[14];

  assign disp_st         = state_q[disp_idx];
  assign acc_req_valid_o = (disp_q != tail_q) && (disp_st == ST_CMT);
  assign acc_req_instr_o = ent_q[disp_idx].instr;
  assign acc_req_rs1_o   = ent_q[disp_idx].rs1;
  assign acc_req_rs2_o   = ent_q[disp_idx].rs2;
  assign acc_req_id_o    = ent_q[disp_idx].id;
  assign req_hs          = acc_req_valid_o & acc_req_ready_i;

  assign head_st         = state_q[head_idx];
  assign head_iss        = (head_st == ST_ISS);
  assign head_we         = ent_q[head_idx].we;
  assign kill_retire     = (head_st == ST_KILL) && (disp_q != head_q);
  assign acc_rsp_ready_o = head_iss & (~head_we | result_ready_i);
  assign rsp_hs          = acc_rsp_valid_i & acc_rsp_ready_o;

  assign result_valid_o = head_iss & head_we & acc_rsp_valid_i;
  assign result_data_o  = (head_iss & head_we) ? acc_rsp_data_i : '0;
  assign result_id_o    = ent_q[head_idx].id;
  assign result_rd_o    = ent_q[head_idx].instr[11:7];

  // Next state: issue at tail, commit/kill search from head, dispatch at disp, retire at head
  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    head_d     = head_q;
    disp_d     = disp_q;
    tail_d     = tail_q;
    commit_hit = 1'b0;

    if (issue_accept_o) begin
      ent_d[tail_idx]   = '{instr: issue_instr_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                            id: issue_id_i, we: issue_writeback_o};
      state_d[tail_idx] = ST_WAIT;
      tail_d            = tail_q + PW'(1);
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && !commit_hit &&
          state_q[head_idx + AW'(i)] == ST_WAIT &&
          ent_q[head_idx + AW'(i)].id == commit_id_i) begin
        state_d[head_idx + AW'(i)] = commit_kill_i ? ST_KILL : ST_CMT;
        commit_hit                 = 1'b1;
      end
    end

    if (req_hs) begin
      state_d[disp_idx] = ST_ISS;
      disp_d            = disp_q + PW'(1);
    end else if ((disp_q != tail_q) && (disp_st == ST_KILL)) begin
      disp_d = disp_q + PW'(1);
    end

    if (kill_retire || rsp_hs) begin
      state_d[head_idx] = ST_FREE;
      head_d            = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{default: ST_FREE};
      ent_q   <= '{default: '0};
      head_q  <= '0;
      disp_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      head_q  <= head_d;
      disp_q  <= disp_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_ma_cvxif_offload_queue.sv
// Directed bench for ma_cvxif_offload_queue: writeback op, reject, full, kill,
// result backpressure and mid-flight reset.
module tb_ma_cvxif_offload_queue;

  localparam logic [31:0] I_WB  = 32'h0000428B; // funct3=100, rd=5, custom-0
  localparam logic [31:0] I_NWB = 32'h0000000B; // rd=0, no writeback
  localparam logic [31:0] I_REJ = 32'h00B50533; // opcode 0x33

  logic        clk_i, rst_ni;
  logic        issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0] issue_instr_i, issue_rs1_i, issue_rs2_i;
  logic [1:0]  issue_id_i;
  logic        commit_valid_i, commit_kill_i;
  logic [1:0]  commit_id_i;
  logic        acc_req_valid_o, acc_req_ready_i;
  logic [31:0] acc_req_instr_o, acc_req_rs1_o, acc_req_rs2_o;
  logic [1:0]  acc_req_id_o;
  logic        acc_rsp_valid_i, acc_rsp_ready_o;
  logic [31:0] acc_rsp_data_i;
  logic        result_valid_o, result_ready_i;
  logic [1:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  logic [1:0]  req_ids [$];
  logic [1:0]  res_ids [$];
  logic [31:0] res_data[$];

  ma_cvxif_offload_queue #(.DEPTH(4), .XLEN(32), .ID_WIDTH(2), .OPCODE(7'b0001011)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_instr_o(acc_req_instr_o), .acc_req_rs1_o(acc_req_rs1_o),
    .acc_req_rs2_o(acc_req_rs2_o), .acc_req_id_o(acc_req_id_o),
    .acc_rsp_valid_i(acc_rsp_valid_i), .acc_rsp_ready_o(acc_rsp_ready_o),
    .acc_rsp_data_i(acc_rsp_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .count_o(count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Record every completed request and result handshake
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (acc_req_valid_o && acc_req_ready_i) req_ids.push_back(acc_req_id_o);
      if (result_valid_o && result_ready_i) begin
        res_ids.push_back(result_id_o);
        res_data.push_back(result_data_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic [1:0] id, input logic [31:0] instr,
                             input logic [31:0] rs1, input logic [31:0] rs2);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    issue_instr_i = instr;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
  endtask

  initial begin
    rst_ni = 1'b0;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; issue_id_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    acc_req_ready_i = 1'b1; acc_rsp_valid_i = 1'b0; acc_rsp_data_i = '0; result_ready_i = 1'b1;

    #12;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_req_valid", 64'(acc_req_valid_o), 64'd0);
    chk("rst_rsp_ready", 64'(acc_rsp_ready_o), 64'd0);
    chk("rst_res_valid", 64'(result_valid_o), 64'd0);
    chk("rst_req_instr", 64'(acc_req_instr_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single writeback op
    drive_issue(2'd1, I_WB, 32'h10, 32'h20);
    #1;
    chk("t1_accept", 64'(issue_accept_o), 64'd1);
    chk("t1_writeback", 64'(issue_writeback_o), 64'd1);
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b1; commit_id_i = 2'd1;
    #1;
    chk("t1_count", 64'(count_o), 64'd1);
    chk("t1_req_early", 64'(acc_req_valid_o), 64'd0);
    tick();
    commit_valid_i = 1'b0;
    #1;
    chk("t1_req_valid", 64'(acc_req_valid_o), 64'd1);
    chk("t1_req_rs1", 64'(acc_req_rs1_o), 64'h10);
    chk("t1_req_rs2", 64'(acc_req_rs2_o), 64'h20);
    chk("t1_req_id", 64'(acc_req_id_o), 64'd1);
    chk("t1_req_instr", 64'(acc_req_instr_o), 64'(I_WB));
    tick();
    acc_rsp_valid_i = 1'b1; acc_rsp_data_i = 32'hDEADBEEF;
    #1;
    chk("t1_req_done", 64'(acc_req_valid_o), 64'd0);
    chk("t1_res_valid", 64'(result_valid_o), 64'd1);
    chk("t1_res_id", 64'(result_id_o), 64'd1);
    chk("t1_res_rd", 64'(result_rd_o), 64'd5);
    chk("t1_res_data", 64'(result_data_o), 64'hDEADBEEF);
    tick();
    acc_rsp_valid_i = 1'b0;
    #1;
    chk("t1_count_end", 64'(count_o), 64'd0);
    chk("t1_res_count", 64'(res_ids.size()), 64'd1);

    // Reject non-custom opcode
    drive_issue(2'd2, I_REJ, 32'h1, 32'h2);
    #1;
    chk("rej_accept", 64'(issue_accept_o), 64'd0);
    chk("rej_writeback", 64'(issue_writeback_o), 64'd0);
    tick();
    issue_valid_i = 1'b0;
    #1;
    chk("rej_count", 64'(count_o), 64'd0);
    chk("rej_req", 64'(acc_req_valid_o), 64'd0);

    // Fill to DEPTH, then free one slot
    req_ids.delete(); res_ids.delete(); res_data.delete();
    for (int i = 0; i < 4; i++) begin
      drive_issue(2'(i), I_NWB, 32'(i), 32'h0);
      #1;
      chk("full_ready_fill", 64'(issue_ready_o), 64'd1);
      chk("full_nwb", 64'(issue_writeback_o), 64'd0);
      tick();
    end
    issue_instr_i = I_NWB; issue_id_i = 2'd0;
    #1;
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    chk("full_no_accept", 64'(issue_accept_o), 64'd0);
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b1; commit_id_i = 2'd0;
    tick();
    commit_valid_i = 1'b0;
    #1;
    chk("full_req_valid", 64'(acc_req_valid_o), 64'd1);
    chk("full_req_id", 64'(acc_req_id_o), 64'd0);
    tick();
    acc_rsp_valid_i = 1'b1; acc_rsp_data_i = 32'h55;
    #1;
    chk("full_rsp_ready", 64'(acc_rsp_ready_o), 64'd1);
    chk("full_no_result", 64'(result_valid_o), 64'd0);
    chk("full_ready_retire", 64'(issue_ready_o), 64'd0);
    tick();
    acc_rsp_valid_i = 1'b0;
    #1;
    chk("full_ready_after", 64'(issue_ready_o), 64'd1);
    chk("full_count_after", 64'(count_o), 64'd3);
    commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 2'd1;
    tick();
    commit_id_i = 2'd2;
    tick();
    commit_id_i = 2'd3;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    repeat (4) tick();
    chk("full_drain_count", 64'(count_o), 64'd0);
    chk("full_drain_reqs", 64'(req_ids.size()), 64'd1);
    chk("full_drain_res", 64'(res_ids.size()), 64'd0);

    // Kill the middle of three
    req_ids.delete(); res_ids.delete(); res_data.delete();
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'(i), I_WB, 32'h100 + 32'(i), 32'h0);
      tick();
    end
    issue_valid_i = 1'b0;
    commit_valid_i = 1'b1; commit_id_i = 2'd0; commit_kill_i = 1'b0;
    tick();
    commit_id_i = 2'd1; commit_kill_i = 1'b1;
    tick();
    commit_id_i = 2'd2; commit_kill_i = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    acc_rsp_valid_i = 1'b1; acc_rsp_data_i = 32'hCAFE0000;
    repeat (10) tick();
    acc_rsp_valid_i = 1'b0;
    tick();
    chk("kill_count", 64'(count_o), 64'd0);
    chk("kill_req_n", 64'(req_ids.size()), 64'd2);
    chk("kill_res_n", 64'(res_ids.size()), 64'd2);
    if (req_ids.size() == 2) begin
      chk("kill_req0", 64'(req_ids[0]), 64'd0);
      chk("kill_req1", 64'(req_ids[1]), 64'd2);
    end
    if (res_ids.size() == 2) begin
      chk("kill_res0", 64'(res_ids[0]), 64'd0);
      chk("kill_res1", 64'(res_ids[1]), 64'd2);
      chk("kill_res1_data", 64'(res_data[1]), 64'hCAFE0000);
    end

    // Result backpressure
    res_ids.delete(); res_data.delete();
    drive_issue(2'd3, I_WB, 32'h33, 32'h44);
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b1; commit_id_i = 2'd3;
    tick();
    commit_valid_i = 1'b0;
    #1;
    chk("bp_req_valid", 64'(acc_req_valid_o), 64'd1);
    tick();
    result_ready_i = 1'b0; acc_rsp_valid_i = 1'b1; acc_rsp_data_i = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rsp_ready", 64'(acc_rsp_ready_o), 64'd0);
      chk("bp_res_valid", 64'(result_valid_o), 64'd1);
      chk("bp_res_data", 64'(result_data_o), 64'h12345678);
      chk("bp_res_id", 64'(result_id_o), 64'd3);
      chk("bp_count", 64'(count_o), 64'd1);
      tick();
    end
    result_ready_i = 1'b1;
    #1;
    chk("bp_rsp_ready_rel", 64'(acc_rsp_ready_o), 64'd1);
    tick();
    acc_rsp_valid_i = 1'b0;
    #1;
    chk("bp_count_end", 64'(count_o), 64'd0);
    chk("bp_res_n", 64'(res_ids.size()), 64'd1);
    if (res_data.size() == 1) chk("bp_res_data_log", 64'(res_data[0]), 64'h12345678);

    // Reset with three entries, head one issued
    drive_issue(2'd0, I_WB, 32'h1, 32'h2);
    tick();
    drive_issue(2'd1, I_WB, 32'h3, 32'h4);
    commit_valid_i = 1'b1; commit_id_i = 2'd0;
    tick();
    drive_issue(2'd2, I_WB, 32'h5, 32'h6);
    commit_valid_i = 1'b0;
    tick();
    issue_valid_i = 1'b0; result_ready_i = 1'b0;
    acc_rsp_valid_i = 1'b1; acc_rsp_data_i = 32'h77;
    #1;
    chk("mr_count_pre", 64'(count_o), 64'd3);
    chk("mr_res_valid_pre", 64'(result_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_count", 64'(count_o), 64'd0);
    chk("mr_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("mr_req_valid", 64'(acc_req_valid_o), 64'd0);
    chk("mr_rsp_ready", 64'(acc_rsp_ready_o), 64'd0);
    chk("mr_res_valid", 64'(result_valid_o), 64'd0);
    chk("mr_res_data", 64'(result_data_o), 64'd0);
    chk("mr_res_id", 64'(result_id_o), 64'd0);
    chk("mr_req_rs1", 64'(acc_req_rs1_o), 64'd0);
    acc_rsp_valid_i = 1'b0; result_ready_i = 1'b1;
    #3 rst_ni = 1'b1;
    tick();
    chk("mr_ready_after", 64'(issue_ready_o), 64'd1);
    chk("mr_count_after", 64'(count_o), 64'd0);
    chk("mr_req_after", 64'(acc_req_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
